// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM pin in clk cycles
module pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [15:0] timeon,
  output logic [15:0] period,
  output logic        valid,
  output logic        signal_lost,
  output logic        level
);
  localparam logic [15:0] TO = 16'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic prev, rise, fall, tmo;
  logic [15:0] cnt, high_cnt, inc;
  assign level = sync[SYNC_STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
  assign inc = cnt == TO ? cnt : cnt + 16'd1;
  // the edge that completes a phase takes priority over the timeout on the same cycle
  assign tmo = cnt == TO && ((state == MEAS_HIGH && !fall) || (state == MEAS_LOW && !rise));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      prev <= level;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      high_cnt <= '0;
      timeon <= '0;
      period <= '0;
      valid <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt <= '0;
      end else if (tmo) begin
        timeon <= '0;
        period <= '0;
        signal_lost <= 1'b1;
        cnt <= '0;
        state <= WAIT_RISE;
      end else begin
        if (state inside {MEAS_HIGH, MEAS_LOW}) cnt <= inc;
        case (state)
          IDLE: state <= WAIT_RISE;
          WAIT_RISE: if (rise) begin
            cnt <= 16'd1;
            state <= MEAS_HIGH;
          end
          MEAS_HIGH: if (fall) begin
            high_cnt <= cnt;
            state <= MEAS_LOW;
          end
          MEAS_LOW: if (rise) begin
            period <= cnt;
            timeon <= high_cnt;
            valid <= 1'b1;
            signal_lost <= 1'b0;
            cnt <= 16'd1;
            state <= MEAS_HIGH;
          end
        endcase
      end
    end
endmodule
